// File: rtl/pipe_control_unit.sv
// Pipelined control unit: decodes the ID opcode into a control bundle and carries it
// through ID/EX, EX/MEM and MEM/WB, with load-use stall and branch/jump flush.
module pipe_control_unit #(
  parameter int ALUOP_W    = 2,
  parameter int REG_ADDR_W = 5,
  parameter int ENABLE_IMM = 1,
  parameter int ENABLE_BNE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid_i,
  input  logic [5:0]            id_opcode_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  branch_taken_i,
  output logic                  stall_o,
  output logic                  if_flush_o,
  output logic                  id_jump_o,
  output logic                  ex_regdst_o,
  output logic                  ex_alusrc_o,
  output logic [ALUOP_W-1:0]    ex_aluop_o,
  output logic                  ex_illegal_o,
  output logic                  mem_branch_o,
  output logic                  mem_branch_ne_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic                  wb_regwrite_o,
  output logic                  wb_memtoreg_o
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(2'b00);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(2'b01);
  localparam logic [ALUOP_W-1:0] ALU_R   = ALUOP_W'(2'b10);
  localparam logic [ALUOP_W-1:0] ALU_LOG = ALUOP_W'(2'b11);

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } wb_t;

  typedef struct packed {
    logic branch;
    logic branch_ne;
    logic mem_read;
    logic mem_write;
  } mem_t;

  typedef struct packed {
    logic               regdst;
    logic               alusrc;
    logic [ALUOP_W-1:0] aluop;
    logic               illegal;
  } ex_t;

  typedef struct packed {
    ex_t  ex;
    mem_t mem;
    wb_t  wb;
  } id_ex_t;

  typedef struct packed {
    mem_t mem;
    wb_t  wb;
  } ex_mem_t;

  id_ex_t                dec;
  id_ex_t                id_ex;
  ex_mem_t               ex_mem;
  wb_t                   mem_wb;
  logic [REG_ADDR_W-1:0] ex_rt;

  logic is_r, is_lw, is_sw, is_beq, is_bne;
  logic is_j, is_addi, is_logi;
  logic uses_rt, hazard, bubble;

  always_comb begin
    is_r    = id_opcode_i == OP_R;
    is_lw   = id_opcode_i == OP_LW;
    is_sw   = id_opcode_i == OP_SW;
    is_beq  = id_opcode_i == OP_BEQ;
    is_bne  = (id_opcode_i == OP_BNE) && (ENABLE_BNE != 0);
    is_j    = id_opcode_i == OP_J;
    is_addi = (id_opcode_i == OP_ADDI) && (ENABLE_IMM != 0);
    is_logi = ((id_opcode_i == OP_ANDI) ||
               (id_opcode_i == OP_ORI) ||
               (id_opcode_i == OP_SLTI)) && (ENABLE_IMM != 0);
  end

  always_comb begin
    dec = '0;
    unique case (1'b1)
      is_r: begin
        dec.ex.regdst   = 1'b1;
        dec.ex.aluop    = ALU_R;
        dec.wb.regwrite = 1'b1;
      end
      is_lw: begin
        dec.ex.alusrc    = 1'b1;
        dec.ex.aluop     = ALU_ADD;
        dec.mem.mem_read = 1'b1;
        dec.wb.memtoreg  = 1'b1;
        dec.wb.regwrite  = 1'b1;
      end
      is_sw: begin
        dec.ex.alusrc     = 1'b1;
        dec.ex.aluop      = ALU_ADD;
        dec.mem.mem_write = 1'b1;
      end
      is_beq: begin
        dec.ex.aluop   = ALU_SUB;
        dec.mem.branch = 1'b1;
      end
      is_bne: begin
        dec.ex.aluop      = ALU_SUB;
        dec.mem.branch_ne = 1'b1;
      end
      is_j: ;
      is_addi: begin
        dec.ex.alusrc   = 1'b1;
        dec.ex.aluop    = ALU_ADD;
        dec.wb.regwrite = 1'b1;
      end
      is_logi: begin
        dec.ex.alusrc   = 1'b1;
        dec.ex.aluop    = ALU_LOG;
        dec.wb.regwrite = 1'b1;
      end
      default: dec.ex.illegal = 1'b1;
    endcase
  end

  // ex_rt is cleared on bubbles, so a stalled load cannot re-trigger the hazard
  always_comb begin
    uses_rt = is_r | is_sw | is_beq | (id_opcode_i == OP_BNE);
    hazard  = id_valid_i & id_ex.mem.mem_read & (ex_rt != '0) &
              ((ex_rt == id_rs_i) | (uses_rt & (ex_rt == id_rt_i)));
    stall_o    = hazard & ~branch_taken_i;
    id_jump_o  = id_valid_i & is_j & ~branch_taken_i;
    if_flush_o = id_jump_o | branch_taken_i;
    bubble     = branch_taken_i | stall_o | ~id_valid_i | is_j;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex <= '0;
      ex_rt <= '0;
    end else if (bubble) begin
      id_ex <= '0;
      ex_rt <= '0;
    end else begin
      id_ex <= dec;
      ex_rt <= id_rt_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_mem <= '0;
    end else if (branch_taken_i) begin
      ex_mem <= '0;
    end else begin
      ex_mem.mem <= id_ex.mem;
      ex_mem.wb  <= id_ex.wb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_wb <= '0;
    else        mem_wb <= ex_mem.wb;
  end

  always_comb begin
    ex_regdst_o     = id_ex.ex.regdst;
    ex_alusrc_o     = id_ex.ex.alusrc;
    ex_aluop_o      = id_ex.ex.aluop;
    ex_illegal_o    = id_ex.ex.illegal;
    mem_branch_o    = ex_mem.mem.branch;
    mem_branch_ne_o = ex_mem.mem.branch_ne;
    mem_read_o      = ex_mem.mem.mem_read;
    mem_write_o     = ex_mem.mem.mem_write;
    wb_regwrite_o   = mem_wb.regwrite;
    wb_memtoreg_o   = mem_wb.memtoreg;
  end

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed bench for pipe_control_unit: default build plus an IMM/BNE-disabled build
// driven from the same inputs.
module tb_pipe_control_unit;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       id_valid_i = 0;
  logic [5:0] id_opcode_i = 0;
  logic [4:0] id_rs_i = 0;
  logic [4:0] id_rt_i = 0;
  logic       branch_taken_i = 0;

  logic       stall, flush, jump, regdst, alusrc, illegal;
  logic [1:0] aluop;
  logic       br, brne, mrd, mwr, rw, m2r;

  logic       b_stall, b_flush, b_jump, b_regdst, b_alusrc, b_illegal;
  logic [1:0] b_aluop;
  logic       b_br, b_brne, b_mrd, b_mwr, b_rw, b_m2r;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, J = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000, ORI = 6'b001101, BAD = 6'b111111;

  pipe_control_unit u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i),
    .id_opcode_i(id_opcode_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .branch_taken_i(branch_taken_i),
    .stall_o(stall), .if_flush_o(flush), .id_jump_o(jump),
    .ex_regdst_o(regdst), .ex_alusrc_o(alusrc), .ex_aluop_o(aluop),
    .ex_illegal_o(illegal), .mem_branch_o(br), .mem_branch_ne_o(brne),
    .mem_read_o(mrd), .mem_write_o(mwr),
    .wb_regwrite_o(rw), .wb_memtoreg_o(m2r)
  );

  pipe_control_unit #(.ENABLE_IMM(0), .ENABLE_BNE(0)) u_min (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i),
    .id_opcode_i(id_opcode_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .branch_taken_i(branch_taken_i),
    .stall_o(b_stall), .if_flush_o(b_flush), .id_jump_o(b_jump),
    .ex_regdst_o(b_regdst), .ex_alusrc_o(b_alusrc), .ex_aluop_o(b_aluop),
    .ex_illegal_o(b_illegal), .mem_branch_o(b_br), .mem_branch_ne_o(b_brne),
    .mem_read_o(b_mrd), .mem_write_o(b_mwr),
    .wb_regwrite_o(b_rw), .wb_memtoreg_o(b_m2r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op,
                       input logic [4:0] rs, input logic [4:0] rt);
    id_valid_i  = v;
    id_opcode_i = op;
    id_rs_i     = rs;
    id_rt_i     = rt;
    #1;
  endtask

  function automatic logic [15:0] regs_a();
    return {3'b0, regdst, alusrc, aluop, illegal, br, brne, mrd, mwr, rw, m2r, 2'b0};
  endfunction

  initial begin
    #23;
    chk("reset_regs", regs_a(), 16'h0);
    chk("reset_stall", {15'b0, stall}, 16'h0);
    rst_n = 1;
    #3;

    // full latency of a load
    drive(1, LW, 5'd1, 5'd5);
    chk("lw_no_stall", {15'b0, stall}, 16'h0);
    tick();
    drive(0, R, 0, 0);
    chk("lw_ex_alusrc", {15'b0, alusrc}, 16'h1);
    chk("lw_ex_aluop", {14'b0, aluop}, 16'h0);
    tick();
    chk("lw_mem_read", {15'b0, mrd}, 16'h1);
    chk("lw_wb_early", {14'b0, rw, m2r}, 16'h0);
    tick();
    chk("lw_wb", {14'b0, rw, m2r}, 16'h3);
    chk("lw_mem_gone", {15'b0, mrd}, 16'h0);

    // load-use on rs
    drive(1, LW, 5'd1, 5'd5);
    tick();
    drive(1, R, 5'd5, 5'd2);
    chk("lu_stall", {15'b0, stall}, 16'h1);
    chk("lu_no_flush", {15'b0, flush}, 16'h0);
    tick();
    chk("lu_ex_bubble", {14'b0, regdst, alusrc}, 16'h0);
    chk("lu_stall_once", {15'b0, stall}, 16'h0);
    chk("lu_lw_in_mem", {15'b0, mrd}, 16'h1);
    tick();
    chk("lu_add_ex", {13'b0, regdst, aluop}, 16'h6);

    // rt = 0 never stalls
    drive(1, LW, 5'd1, 5'd0);
    tick();
    drive(1, R, 5'd0, 5'd0);
    chk("lu_rt0", {15'b0, stall}, 16'h0);

    // store reads rt, addi does not
    drive(1, LW, 5'd1, 5'd5);
    tick();
    drive(1, ADDI, 5'd3, 5'd5);
    chk("lu_addi_rt", {15'b0, stall}, 16'h0);
    drive(1, SW, 5'd3, 5'd5);
    chk("lu_sw_rt", {15'b0, stall}, 16'h1);
    drive(0, R, 0, 0);
    tick();
    tick();
    tick();

    // taken branch beats a load-use hazard
    drive(1, BEQ, 5'd1, 5'd2);
    tick();
    drive(1, LW, 5'd1, 5'd5);
    tick();
    chk("br_in_mem", {15'b0, br}, 16'h1);
    drive(1, R, 5'd5, 5'd6);
    branch_taken_i = 1;
    #1;
    chk("br_stall", {15'b0, stall}, 16'h0);
    chk("br_flush", {15'b0, flush}, 16'h1);
    tick();
    branch_taken_i = 0;
    drive(0, R, 0, 0);
    chk("br_flushed", regs_a() & 16'h1FF0, 16'h0);
    chk("br_mem_zero", {12'b0, br, brne, mrd, mwr}, 16'h0);

    // jump
    drive(1, J, 5'd0, 5'd0);
    chk("j_jump", {15'b0, jump}, 16'h1);
    chk("j_flush", {15'b0, flush}, 16'h1);
    tick();
    drive(0, R, 0, 0);
    chk("j_ex_zero", regs_a(), 16'h0);

    // reduced build vs default build
    drive(1, ADDI, 5'd1, 5'd2);
    tick();
    chk("min_addi_ill", {15'b0, b_illegal}, 16'h1);
    chk("min_addi_zero", {13'b0, b_regdst, b_alusrc, b_aluop != 0}, 16'h0);
    chk("def_addi", {14'b0, alusrc, illegal}, 16'h2);
    drive(1, BAD, 5'd1, 5'd2);
    tick();
    chk("bad_ill", {14'b0, illegal, b_illegal}, 16'h3);
    drive(1, BNE, 5'd1, 5'd2);
    tick();
    chk("bne_ill", {14'b0, illegal, b_illegal}, 16'h1);
    drive(1, ORI, 5'd1, 5'd2);
    tick();
    drive(0, R, 0, 0);
    chk("ori_ex", {13'b0, alusrc, aluop}, 16'h7);
    chk("min_ori_ill", {15'b0, b_illegal}, 16'h1);
    tick();
    tick();
    chk("ori_wb", {15'b0, rw}, 16'h1);
    chk("min_ori_wb", {15'b0, b_rw}, 16'h0);

    // asynchronous reset with a load in ID/EX and a hazard pending
    drive(1, LW, 5'd1, 5'd5);
    tick();
    drive(1, R, 5'd5, 5'd2);
    chk("rst_pre_stall", {15'b0, stall}, 16'h1);
    #1;
    rst_n = 0;
    #1;
    chk("rst_async_regs", regs_a(), 16'h0);
    chk("rst_stall", {15'b0, stall}, 16'h0);
    drive(1, J, 0, 0);
    chk("rst_comb_jump", {15'b0, jump}, 16'h1);
    #3;
    rst_n = 1;
    drive(1, LW, 5'd1, 5'd5);
    chk("rst_no_resid", {15'b0, stall}, 16'h0);
    tick();
    drive(0, R, 0, 0);
    chk("rst_first_ex", {15'b0, alusrc}, 16'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_control_unit.md
Name: pipe_control_unit

Overview:
- Successor to the single-cycle opcode decoder; sits between the IF/ID register and the datapath.
- Decodes the ID-stage opcode into a full control bundle, which it carries through the ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and inserts bubbles, and generates flush for jumps and taken branches.
- Every opcode yields a fully defined bundle; no latched outputs.

Parameters:
- ALUOP_W, 2, ALUOp field width (>=2); encodings below are zero-extended.
- REG_ADDR_W, 5, register specifier width.
- ENABLE_IMM, 1, decode addi/andi/ori/slti; when 0 they are illegal.
- ENABLE_BNE, 1, decode bne; when 0 it is illegal.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid_i  in  1  IF/ID holds a real instruction.
- id_opcode_i  in  6  instruction[31:26].
- id_rs_i  in  REG_ADDR_W  instruction rs.
- id_rt_i  in  REG_ADDR_W  instruction rt.
- branch_taken_i  in  1  MEM-stage branch resolved taken.
- stall_o  out  1  hold PC and IF/ID; combinational.
- if_flush_o  out  1  zero IF/ID; combinational.
- id_jump_o  out  1  select jump target for PC; combinational.
- ex_regdst_o  out  1  EX: write rd.
- ex_alusrc_o  out  1  EX: immediate operand.
- ex_aluop_o  out  ALUOP_W  EX: ALU control class.
- ex_illegal_o  out  1  EX: instruction was illegal.
- mem_branch_o  out  1  MEM: beq.
- mem_branch_ne_o  out  1  MEM: bne.
- mem_read_o  out  1  MEM: load.
- mem_write_o  out  1  MEM: store.
- wb_regwrite_o  out  1  WB: register write.
- wb_memtoreg_o  out  1  WB: select memory data.

Behaviour:
- Decode table (unlisted fields are 0):
  - 000000 R-type: regdst, regwrite, aluop=10.
  - 100011 lw: alusrc, memread, memtoreg, regwrite, aluop=00.
  - 101011 sw: alusrc, memwrite, aluop=00.
  - 000100 beq: branch, aluop=01.
  - 000101 bne: branch_ne, aluop=01.
  - 000010 j: jump only.
  - 001000 addi: alusrc, regwrite, aluop=00.
  - 001100/001101/001010 andi/ori/slti: alusrc, regwrite, aluop=11.
  - Any other opcode, or a parameter-disabled one: all-zero bundle plus illegal=1.
- Bubble = all stage fields 0 (illegal also 0).
- uses_rt = R-type | sw | beq | bne.
- hazard = id_valid_i & mem_read held in ID/EX & ex_rt != 0 & (ex_rt == id_rs_i | (uses_rt & ex_rt == id_rt_i)).
  - ex_rt is id_rt_i captured into ID/EX.
- stall_o = hazard & ~branch_taken_i.
- id_jump_o = id_valid_i & opcode==j & ~branch_taken_i.
- if_flush_o = id_jump_o | branch_taken_i.
- ID/EX update each edge:
  - branch_taken_i=1 -> bubble.
  - stall_o=1 -> bubble.
  - id_valid_i=0 -> bubble.
  - otherwise -> decoded bundle.
  - A jump loads a bubble (jump needs no later stage).
- EX/MEM takes the ID/EX MEM+WB fields; branch_taken_i=1 -> zeroed.
- MEM/WB takes the EX/MEM WB fields; never flushed.
- Latency: EX outputs 1 cycle after ID; MEM outputs 2 cycles; WB outputs 3 cycles.
- branch_taken_i has priority over stall and jump in the same cycle.
- Load-use stall lasts exactly one cycle: the bubble clears ID/EX mem_read.
- rst_n low: all stage registers (incl. ex_rt, illegal) clear to 0 immediately, independent of clk.
  - Combinational outputs follow inputs; stall_o is 0 during reset.
- Reset released mid-stream: first valid ID instruction reaches EX one edge later; no residual hazard.

Test Plan:
- Reset: rst_n=0 mid-stream with lw in ID/EX -> all registered outputs 0 before the next clk edge; stall_o=0.
- Full latency: lw ($rt=5, $rs=1) valid -> mem_read_o=1 at cycle 2; wb_regwrite_o=1 and wb_memtoreg_o=1 at cycle 3.
- Load-use: lw rt=5 then add rs=5 -> stall_o=1 for one cycle, EX bubble, add reaches EX one cycle late.
  - Repeat with rt=0 -> no stall.
  - Repeat with sw using rt=5 -> stall.
- beq in MEM with branch_taken_i=1 while ID has a hazard -> stall_o=0, if_flush_o=1; the next EX and MEM bundles are all zero.
- j (000010) valid -> id_jump_o=1, if_flush_o=1; next-cycle EX bundle zero, ex_illegal_o=0.
- ENABLE_IMM=0, ENABLE_BNE=0 build:
  - addi -> ex_illegal_o=1 with zero bundle.
  - opcode 111111 -> ex_illegal_o=1.
  - ori under the default build -> ex_alusrc_o=1, ex_aluop_o=11, wb_regwrite_o=1 two cycles later.
